// File: rtl/split_hold_pkg.sv
// split_pkg: shared constants and helpers for the split_hold demultiplexer.
//   LANE_G / LANE_S : lane index encoding reported on last_sel.
//   cnt_width(hold) : width of a lane's hold-down counter, never below 1 bit.
package split_pkg;

  localparam logic LANE_G = 1'b0;
  localparam logic LANE_S = 1'b1;

  // Counter must hold HOLD-1. $clog2(1) is 0, so clamp to a single bit.
  function automatic int cnt_width(input int hold);
    return (hold <= 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/split_hold_if.sv
// split_hold_if: producer-side and lane-side signals of split_hold.
//   go_G, go_S : capture events for lane 0 / lane 1.
//   in         : shared data input, sampled only in a go cycle.
//   out0/out1  : per-lane data.
//   valid0/1   : per-lane live flags.
//   last_sel   : lane of the most recent accepted capture.
//   conflict   : sticky simultaneous-go flag.
// master = producer/observer side, slave = split_hold itself.
interface split_hold_if #(
  parameter int WIDTH = 32
);
  logic             go_G;
  logic             go_S;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic             valid0;
  logic             valid1;
  logic             last_sel;
  logic             conflict;

  modport master (
    output go_G, go_S, in,
    input  out0, out1, valid0, valid1, last_sel, conflict
  );

  modport slave (
    input  go_G, go_S, in,
    output out0, out1, valid0, valid1, last_sel, conflict
  );
endinterface

// File: rtl/split_hold_lane.sv
// split_lane: one output lane of split_hold.
// Captures in on go and keeps valid high for HOLD cycles counting the go
// cycle. The go cycle itself is bypassed combinationally (0-cycle latency).
//   clk   : clock, posedge.
//   reset : synchronous, active-high; clears data and counter.
//   go    : capture event.
//   in    : data to capture.
//   out   : in during a go cycle, otherwise the last captured value.
//   valid : high for HOLD consecutive cycles from the go cycle.
module split_lane
  import split_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  if (HOLD < 1) begin : g_bad_hold
    $error("split_lane: HOLD must be >= 1");
  end

  localparam int CW = cnt_width(HOLD);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             go_eff;

  // Reset beats a same-cycle go, including on the bypass path.
  assign go_eff = go & ~reset;

  always_comb begin
    reg_d = reg_q;
    cnt_d = cnt_q;
    if (go_eff) begin
      reg_d = in;
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q <= '0;
      cnt_q <= '0;
    end else begin
      reg_q <= reg_d;
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts the remaining cycles after the go cycle, so the go cycle
  // itself is covered by the bypass term.
  assign out   = go_eff ? in : reg_q;
  assign valid = go_eff | (cnt_q != '0);

endmodule

// File: rtl/split_hold.sv
// split_hold: steers one data input onto two held output lanes.
// Lane 0 captures on go_G, lane 1 on go_S; G wins a same-cycle collision.
//   clk   : clock, posedge.
//   reset : synchronous, active-high.
//   bus   : split_hold_if slave (go_G, go_S, in, out0/1, valid0/1,
//           last_sel, conflict).
module split_hold
  import split_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int HOLD  = 1
) (
  input  logic         clk,
  input  logic         reset,
  split_hold_if.slave  bus
);

  logic go0, go1;
  logic last_sel_q, last_sel_d;
  logic conflict_q, conflict_d;

  // G priority: on collision lane 1 sees no go and keeps counting down.
  assign go0 = bus.go_G;
  assign go1 = bus.go_S & ~bus.go_G;

  split_lane #(.WIDTH(WIDTH), .HOLD(HOLD)) u_lane0 (
    .clk   (clk),
    .reset (reset),
    .go    (go0),
    .in    (bus.in),
    .out   (bus.out0),
    .valid (bus.valid0)
  );

  split_lane #(.WIDTH(WIDTH), .HOLD(HOLD)) u_lane1 (
    .clk   (clk),
    .reset (reset),
    .go    (go1),
    .in    (bus.in),
    .out   (bus.out1),
    .valid (bus.valid1)
  );

  always_comb begin
    last_sel_d = last_sel_q;
    conflict_d = conflict_q;
    if (go0) begin
      last_sel_d = LANE_G;
    end else if (go1) begin
      last_sel_d = LANE_S;
    end
    if (bus.go_G & bus.go_S) begin
      conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sel_q <= LANE_G;
      conflict_q <= 1'b0;
    end else begin
      last_sel_q <= last_sel_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.last_sel = last_sel_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_split_hold.sv
// Directed bench for split_hold: three instances (HOLD = 3, 1, 4).
// Inputs change 2 time units after posedge; outputs are sampled 1 unit later.
module tb_split_hold;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  split_hold_if #(.WIDTH(W)) bus_a ();
  split_hold_if #(.WIDTH(W)) bus_b ();
  split_hold_if #(.WIDTH(W)) bus_c ();

  split_hold #(.WIDTH(W), .HOLD(3)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  split_hold #(.WIDTH(W), .HOLD(1)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
  split_hold #(.WIDTH(W), .HOLD(4)) dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next posedge, leaving room to drive inputs.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.go_G = 1'b1; bus_a.go_S = 1'b0; bus_a.in = 32'hAA;
    bus_b.go_G = 1'b0; bus_b.go_S = 1'b0; bus_b.in = '0;
    bus_c.go_G = 1'b0; bus_c.go_S = 1'b0; bus_c.in = '0;

    // Reset with go_G held high for two cycles.
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.go_G = 1'b0;
    settle();
    chk("rst_out0", bus_a.out0, 0);
    chk("rst_out1", bus_a.out1, 0);
    chk("rst_valid0", bus_a.valid0, 0);
    chk("rst_valid1", bus_a.valid1, 0);
    chk("rst_last_sel", bus_a.last_sel, 0);
    chk("rst_conflict", bus_a.conflict, 0);

    // Single capture on lane 0, HOLD=3.
    tick();
    bus_a.go_G = 1'b1; bus_a.in = 32'h1234;
    settle();
    chk("cap_t0_out0", bus_a.out0, 32'h1234);
    chk("cap_t0_valid0", bus_a.valid0, 1);
    chk("cap_t0_valid1", bus_a.valid1, 0);
    chk("cap_t0_out1", bus_a.out1, 0);
    tick();
    bus_a.go_G = 1'b0; bus_a.in = 32'hDEAD;
    settle();
    chk("cap_t1_out0", bus_a.out0, 32'h1234);
    chk("cap_t1_valid0", bus_a.valid0, 1);
    chk("cap_t1_last_sel", bus_a.last_sel, 0);
    tick(); settle();
    chk("cap_t2_valid0", bus_a.valid0, 1);
    tick(); settle();
    chk("cap_t3_valid0", bus_a.valid0, 0);
    chk("cap_t3_out0", bus_a.out0, 32'h1234);
    chk("cap_t3_valid1", bus_a.valid1, 0);

    // Re-trigger on lane 1.
    tick();
    bus_a.go_S = 1'b1; bus_a.in = 32'd5;
    settle();
    chk("rt_t0_out1", bus_a.out1, 5);
    chk("rt_t0_valid1", bus_a.valid1, 1);
    tick();
    bus_a.in = 32'd9;
    settle();
    chk("rt_t1_out1", bus_a.out1, 9);
    chk("rt_t1_valid1", bus_a.valid1, 1);
    chk("rt_t1_last_sel", bus_a.last_sel, 1);
    tick();
    bus_a.go_S = 1'b0; bus_a.in = 32'hFFFF;
    settle();
    chk("rt_t2_valid1", bus_a.valid1, 1);
    chk("rt_t2_out1", bus_a.out1, 9);
    tick(); settle();
    chk("rt_t3_valid1", bus_a.valid1, 1);
    tick(); settle();
    chk("rt_t4_valid1", bus_a.valid1, 0);
    chk("rt_t4_out1", bus_a.out1, 9);
    chk("rt_t4_out0", bus_a.out0, 32'h1234);

    // Collision during an active lane 1 hold.
    tick();
    bus_a.go_S = 1'b1; bus_a.in = 32'h55;
    tick();
    bus_a.go_G = 1'b1; bus_a.in = 32'h77;
    settle();
    chk("col_out0", bus_a.out0, 32'h77);
    chk("col_valid0", bus_a.valid0, 1);
    chk("col_out1", bus_a.out1, 32'h55);
    chk("col_valid1", bus_a.valid1, 1);
    chk("col_conflict_pre", bus_a.conflict, 0);
    tick();
    bus_a.go_G = 1'b0; bus_a.go_S = 1'b0; bus_a.in = 32'h0;
    settle();
    chk("col_conflict", bus_a.conflict, 1);
    chk("col_last_sel", bus_a.last_sel, 0);
    chk("col_out1_kept", bus_a.out1, 32'h55);
    chk("col_valid1_u2", bus_a.valid1, 1);
    tick(); settle();
    chk("col_valid1_u3", bus_a.valid1, 0);
    chk("col_out0_kept", bus_a.out0, 32'h77);
    tick(); tick(); settle();
    chk("col_conflict_sticky", bus_a.conflict, 1);
    tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    settle();
    chk("col_conflict_cleared", bus_a.conflict, 0);

    // HOLD=1, alternating lanes.
    tick();
    bus_b.go_G = 1'b1; bus_b.in = 32'd1;
    settle();
    chk("h1_c0_valid0", bus_b.valid0, 1);
    chk("h1_c0_valid1", bus_b.valid1, 0);
    chk("h1_c0_out0", bus_b.out0, 1);
    tick();
    bus_b.go_G = 1'b0; bus_b.go_S = 1'b1; bus_b.in = 32'd2;
    settle();
    chk("h1_c1_valid0", bus_b.valid0, 0);
    chk("h1_c1_valid1", bus_b.valid1, 1);
    chk("h1_c1_out1", bus_b.out1, 2);
    chk("h1_c1_out0", bus_b.out0, 1);
    tick();
    bus_b.go_G = 1'b1; bus_b.go_S = 1'b0; bus_b.in = 32'd3;
    settle();
    chk("h1_c2_valid0", bus_b.valid0, 1);
    chk("h1_c2_valid1", bus_b.valid1, 0);
    chk("h1_c2_out0", bus_b.out0, 3);
    tick();
    bus_b.go_G = 1'b0; bus_b.go_S = 1'b1; bus_b.in = 32'd4;
    settle();
    chk("h1_c3_valid0", bus_b.valid0, 0);
    chk("h1_c3_valid1", bus_b.valid1, 1);
    chk("h1_c3_out1", bus_b.out1, 4);
    tick();
    bus_b.go_S = 1'b0; bus_b.in = 32'd0;
    settle();
    chk("h1_idle_valid0", bus_b.valid0, 0);
    chk("h1_idle_valid1", bus_b.valid1, 0);
    chk("h1_idle_out0", bus_b.out0, 3);
    chk("h1_idle_out1", bus_b.out1, 4);
    chk("h1_idle_conflict", bus_b.conflict, 0);
    chk("h1_idle_last_sel", bus_b.last_sel, 1);

    // HOLD=4, reset aborts an in-flight hold.
    tick();
    bus_c.go_G = 1'b1; bus_c.in = 32'hF0;
    settle();
    chk("rm_t0_valid0", bus_c.valid0, 1);
    chk("rm_t0_out0", bus_c.out0, 32'hF0);
    tick();
    bus_c.go_G = 1'b0; bus_c.in = 32'h0;
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    settle();
    chk("rm_t2_valid0", bus_c.valid0, 0);
    chk("rm_t2_out0", bus_c.out0, 0);
    tick(); settle();
    chk("rm_t3_valid0", bus_c.valid0, 0);
    tick(); settle();
    chk("rm_t4_valid0", bus_c.valid0, 0);
    chk("rm_t4_valid1", bus_c.valid1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
